ir_tx_arbiter: RTL

- Shares the single IrDA transmitter between two byte FIFOs, arbitrating round-robin.
  - Source 0: the UART receive-path FIFO.
  - Source 1: a local/status message FIFO.
- Enforces half-duplex link discipline: it never launches a byte while the IR receiver is mid-frame, and it holds a turnaround guard after every transmit and every receive.
- Sits between the FIFO controllers and the IR transmitter. It replaces the single-source read/send sequencer.

---
 rtl/ir_tx_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ir_tx_arbiter.sv
// ir_tx_arbiter: shares one IrDA transmitter between two byte FIFOs
// (source 0 = UART receive path, source 1 = local/status messages).
// It keeps to half-duplex link discipline: no launch while the IR receiver
// is mid-frame, and a turnaround guard of TURN_CYC quiet cycles after every
// transmit and every receive.
// Build option: define IR_ARB_FIXED_PRIO_EN for fixed priority (source 0
// always first). Without it, arbitration is round-robin.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | link free; launch when the transmitter is ready, the receiver is quiet and a FIFO has data
// READ      | read strobe issued; waiting for the FIFO output to settle
// LOAD      | capture the FIFO byte into out_data
// SEND      | send strobe high, out_data stable
// WAIT_ACK  | waiting for the transmitter to drop tx_available
// WAIT_DONE | frame on air; waiting for tx_available to return
// GUARD     | counting quiet cycles; any receive activity restarts the count
module ir_tx_arbiter #(
    parameter int DATA_W   = 8,
    parameter int TURN_CYC = 16,
    parameter int CNT_W    = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fifo0_empty,
    input  logic [DATA_W-1:0] fifo0_data,
    output logic              fifo0_rd,
    input  logic              fifo1_empty,
    input  logic [DATA_W-1:0] fifo1_data,
    output logic              fifo1_rd,
    input  logic              rx_busy,
    input  logic              tx_available,
    output logic [DATA_W-1:0] out_data,
    output logic              send,
    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE, READ, LOAD, SEND, WAIT_ACK, WAIT_DONE, GUARD
    } state_t;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(TURN_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              rx_busy_q;
    logic              rd0_d, rd1_d, send_d;
    logic [1:0]        grant_d;
    logic [DATA_W-1:0] out_data_d;
    logic              launch, pick0, rx_fall;

    assign launch  = tx_available && !rx_busy && (!fifo0_empty || !fifo1_empty);
    assign rx_fall = rx_busy_q && !rx_busy;

`ifdef IR_ARB_FIXED_PRIO_EN
    assign pick0 = !fifo0_empty;
`else
    // last_q = 1 means source 1 was served last, so source 0 wins a tie.
    assign pick0 = !fifo0_empty && (fifo1_empty || last_q);
`endif

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        grant_d    = grant;
        out_data_d = out_data;
        rd0_d      = 1'b0;
        rd1_d      = 1'b0;
        send_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // A receive that just ended must be followed by a full guard.
                if (rx_fall) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                end else if (launch) begin
                    state_d = READ;
                    if (pick0) begin
                        rd0_d   = 1'b1;
                        grant_d = 2'b01;
                        last_d  = 1'b0;
                    end else begin
                        rd1_d   = 1'b1;
                        grant_d = 2'b10;
                        last_d  = 1'b1;
                    end
                end
            end
            READ: state_d = LOAD;
            LOAD: begin
                out_data_d = grant[1] ? fifo1_data : fifo0_data;
                send_d     = 1'b1;
                state_d    = SEND;
            end
            SEND: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (!tx_available) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_available) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                end
            end
            GUARD: begin
                if (rx_busy) begin
                    cnt_d = '0;
                end else if (cnt_q == GUARD_LAST) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, guard counter, pointer and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            rx_busy_q <= 1'b0;
            fifo0_rd  <= 1'b0;
            fifo1_rd  <= 1'b0;
            send      <= 1'b0;
            out_data  <= '0;
            grant     <= 2'b00;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rx_busy_q <= rx_busy;
            fifo0_rd  <= rd0_d;
            fifo1_rd  <= rd1_d;
            send      <= send_d;
            out_data  <= out_data_d;
            grant     <= grant_d;
            busy      <= (state_d != IDLE);
        end
    end

endmodule
